// File: rtl/sa_tile_matmul_seq.sv
// sa_tile_matmul_seq: tiled A x B sequencer in front of one SA_wrapper.
// K-slices are summed per output tile in a signed saturating accumulator.
module sa_tile_matmul_seq #(
  parameter int D_W   = 8,
  parameter int ACC_W = 20,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_T   = 16,
  parameter int M     = 32,
  parameter int N     = 32,
  parameter int K     = 128
) (
  input  logic                            I_CLK,
  input  logic                            I_ASYN_RSTN,
  input  logic                            I_SYNC_RSTN,
  input  logic                            I_START,
  input  logic [M*K*D_W-1:0]              I_MAT_A,
  input  logic [K*N*D_W-1:0]              I_MAT_B,
  input  logic                            I_SA_VLD,
  input  logic [SA_R*SA_C*D_W-1:0]        I_SA_RESULT,
  output logic                            O_SA_START,
  output logic                            O_SA_CLEARN,
  output logic [7:0]                      O_M_DIM,
  output logic [SA_R*K_T*D_W-1:0]         O_MAT_1,
  output logic [K_T*SA_C*D_W-1:0]         O_MAT_2,
  output logic                            O_DATA_VLD,
  output logic [$clog2(M/SA_R):0]         O_TILE_ROW,
  output logic [$clog2(N/SA_C):0]         O_TILE_COL,
  output logic [SA_R*SA_C*ACC_W-1:0]      O_OUT,
  output logic                            O_BUSY,
  output logic                            O_DONE
);

  localparam int TR_N = M / SA_R;
  localparam int TC_N = N / SA_C;
  localparam int TK_N = K / K_T;
  localparam int TRW  = $clog2(TR_N) + 1;
  localparam int TCW  = $clog2(TC_N) + 1;
  localparam int TKW  = $clog2(TK_N) + 1;
  localparam int E    = SA_R * SA_C;

  localparam logic [TRW-1:0] TR_LAST = TRW'(TR_N - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TC_N - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TK_N - 1);

  localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_WAIT,
    S_ACC,  S_EMIT, S_CLR,  S_DONE
  } state_t;

  state_t                       r_state;
  logic [TRW-1:0]               r_tr;
  logic [TCW-1:0]               r_tc;
  logic [TKW-1:0]               r_tk;
  logic                         r_fin;
  logic                         r_sa_start;
  logic                         r_clearn;
  logic                         r_dvld;
  logic [TRW-1:0]               r_tile_row;
  logic [TCW-1:0]               r_tile_col;
  logic                         r_busy;
  logic                         r_done;
  logic [SA_R*K_T*D_W-1:0]      r_mat1;
  logic [K_T*SA_C*D_W-1:0]      r_mat2;
  logic [E*ACC_W-1:0]           r_out;
  logic [ACC_W-1:0]             r_acc [E];

  logic [ACC_W:0]               w_sum     [E];
  logic [ACC_W-1:0]             w_acc_nxt [E];
  int                           w_rbase;
  int                           w_cbase;
  int                           w_kbase;

  assign w_rbase = int'(r_tr) * SA_R;
  assign w_cbase = int'(r_tc) * SA_C;
  assign w_kbase = int'(r_tk) * K_T;

  // overflow shows up as the two top bits of the widened sum disagreeing
  always_comb begin
    for (int e = 0; e < E; e++) begin
      w_sum[e] = {r_acc[e][ACC_W-1], r_acc[e]}
               + {{(ACC_W+1-D_W){I_SA_RESULT[e*D_W+D_W-1]}},
                  I_SA_RESULT[e*D_W +: D_W]};
      if (w_sum[e][ACC_W] != w_sum[e][ACC_W-1])
        w_acc_nxt[e] = w_sum[e][ACC_W] ? MINV : MAXV;
      else
        w_acc_nxt[e] = w_sum[e][ACC_W-1:0];
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      r_state    <= S_IDLE;
      r_tr       <= '0;
      r_tc       <= '0;
      r_tk       <= '0;
      r_fin      <= 1'b0;
      r_sa_start <= 1'b0;
      r_clearn   <= 1'b1;
      r_dvld     <= 1'b0;
      r_tile_row <= '0;
      r_tile_col <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      r_state    <= S_IDLE;
      r_tr       <= '0;
      r_tc       <= '0;
      r_tk       <= '0;
      r_fin      <= 1'b0;
      r_sa_start <= 1'b0;
      r_clearn   <= 1'b1;
      r_dvld     <= 1'b0;
      r_tile_row <= '0;
      r_tile_col <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sa_start <= 1'b0;
      r_clearn   <= 1'b1;
      r_dvld     <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (I_START) begin
            r_tr    <= '0;
            r_tc    <= '0;
            r_tk    <= '0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sa_start <= 1'b1;
          r_state    <= S_FIRE;
        end
        S_FIRE: r_state <= S_WAIT;
        S_WAIT: begin
          if (I_SA_VLD)
            r_state <= S_ACC;
        end
        S_ACC: begin
          if (r_tk != TK_LAST) begin
            r_tk     <= r_tk + 1'b1;
            r_clearn <= 1'b0;
            r_state  <= S_CLR;
          end else begin
            r_dvld     <= 1'b1;
            r_tile_row <= r_tr;
            r_tile_col <= r_tc;
            r_state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          r_tk     <= '0;
          r_clearn <= 1'b0;
          r_state  <= S_CLR;
          if (r_tc == TC_LAST) begin
            r_tc  <= '0;
            r_tr  <= r_tr + 1'b1;
            r_fin <= (r_tr == TR_LAST);
          end else begin
            r_tc <= r_tc + 1'b1;
          end
        end
        S_CLR: begin
          if (r_fin) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      r_mat1 <= '0;
      r_mat2 <= '0;
      r_out  <= '0;
      for (int e = 0; e < E; e++)
        r_acc[e] <= '0;
    end else if (!I_SYNC_RSTN) begin
      r_mat1 <= '0;
      r_mat2 <= '0;
      r_out  <= '0;
      for (int e = 0; e < E; e++)
        r_acc[e] <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        for (int i = 0; i < SA_R; i++)
          for (int j = 0; j < K_T; j++)
            r_mat1[(i*K_T+j)*D_W +: D_W] <=
              I_MAT_A[((w_rbase+i)*K + w_kbase+j)*D_W +: D_W];
        for (int j = 0; j < K_T; j++)
          for (int c = 0; c < SA_C; c++)
            r_mat2[(j*SA_C+c)*D_W +: D_W] <=
              I_MAT_B[((w_kbase+j)*N + w_cbase+c)*D_W +: D_W];
      end
      if (r_state == S_WAIT && I_SA_VLD)
        for (int e = 0; e < E; e++)
          r_acc[e] <= w_acc_nxt[e];
      if (r_state == S_ACC && r_tk == TK_LAST)
        for (int e = 0; e < E; e++)
          r_out[e*ACC_W +: ACC_W] <= r_acc[e];
      if (r_state == S_EMIT)
        for (int e = 0; e < E; e++)
          r_acc[e] <= '0;
    end
  end

  assign O_SA_START  = r_sa_start;
  assign O_SA_CLEARN = r_clearn;
  assign O_M_DIM     = 8'(K_T);
  assign O_MAT_1     = r_mat1;
  assign O_MAT_2     = r_mat2;
  assign O_DATA_VLD  = r_dvld;
  assign O_TILE_ROW  = r_tile_row;
  assign O_TILE_COL  = r_tile_col;
  assign O_OUT       = r_out;
  assign O_BUSY      = r_busy;
  assign O_DONE      = r_done;

endmodule

// File: tb/tb_sa_tile_matmul_seq.sv
// Bench for sa_tile_matmul_seq: three configurations, an SA stub each,
// and a plain integer matmul reference for the emitted tiles.
module tb_sa_tile_matmul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic srst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic          st   [3];
  logic          vld  [3];
  logic          clrn [3];
  logic [2047:0] m1   [3];
  logic [2047:0] m2   [3];
  logic [2047:0] res  [3];
  bit            sconst [3];
  logic [7:0]    sval   [3];

  // u1: 32x32, K=128, ACC_W=20
  logic             start1, dv1, busy1, done1;
  logic [32767:0]   a1, b1;
  logic [1:0]       row1, col1;
  logic [5119:0]    out1;
  logic [7:0]       mdim1;
  // u2: 16x16, K=16, ACC_W=20
  logic             start2, dv2, busy2, done2;
  logic [2047:0]    a2, b2;
  logic [0:0]       row2, col2;
  logic [5119:0]    out2;
  logic [7:0]       mdim2;
  // u3: 16x16, K=128, ACC_W=10
  logic             start3, dv3, busy3, done3;
  logic [16383:0]   a3, b3;
  logic [0:0]       row3, col3;
  logic [2559:0]    out3;
  logic [7:0]       mdim3;

  sa_tile_matmul_seq #(.M(32), .N(32), .K(128)) u1 (
    .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_SYNC_RSTN(srst_n),
    .I_START(start1), .I_MAT_A(a1), .I_MAT_B(b1),
    .I_SA_VLD(vld[0]), .I_SA_RESULT(res[0]),
    .O_SA_START(st[0]), .O_SA_CLEARN(clrn[0]), .O_M_DIM(mdim1),
    .O_MAT_1(m1[0]), .O_MAT_2(m2[0]), .O_DATA_VLD(dv1),
    .O_TILE_ROW(row1), .O_TILE_COL(col1), .O_OUT(out1),
    .O_BUSY(busy1), .O_DONE(done1));

  sa_tile_matmul_seq #(.M(16), .N(16), .K(16)) u2 (
    .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_SYNC_RSTN(srst_n),
    .I_START(start2), .I_MAT_A(a2), .I_MAT_B(b2),
    .I_SA_VLD(vld[1]), .I_SA_RESULT(res[1]),
    .O_SA_START(st[1]), .O_SA_CLEARN(clrn[1]), .O_M_DIM(mdim2),
    .O_MAT_1(m1[1]), .O_MAT_2(m2[1]), .O_DATA_VLD(dv2),
    .O_TILE_ROW(row2), .O_TILE_COL(col2), .O_OUT(out2),
    .O_BUSY(busy2), .O_DONE(done2));

  sa_tile_matmul_seq #(.M(16), .N(16), .K(128), .ACC_W(10)) u3 (
    .I_CLK(clk), .I_ASYN_RSTN(rst_n), .I_SYNC_RSTN(srst_n),
    .I_START(start3), .I_MAT_A(a3), .I_MAT_B(b3),
    .I_SA_VLD(vld[2]), .I_SA_RESULT(res[2]),
    .O_SA_START(st[2]), .O_SA_CLEARN(clrn[2]), .O_M_DIM(mdim3),
    .O_MAT_1(m1[2]), .O_MAT_2(m2[2]), .O_DATA_VLD(dv3),
    .O_TILE_ROW(row3), .O_TILE_COL(col3), .O_OUT(out3),
    .O_BUSY(busy3), .O_DONE(done3));

  // SA behaviour: 16x16x16 int8 product, wrapped to 8 bits
  function automatic logic [2047:0] sa_mul(input logic [2047:0] x,
                                           input logic [2047:0] y);
    logic [2047:0] z;
    int s, p, q;
    z = '0;
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 16; c++) begin
        s = 0;
        for (int j = 0; j < 16; j++) begin
          p = $signed(x[(i*16+j)*8 +: 8]);
          q = $signed(y[(j*16+c)*8 +: 8]);
          s += p * q;
        end
        z[(i*16+c)*8 +: 8] = 8'(s);
      end
    return z;
  endfunction

  // random latency; stray valids only when no pass is outstanding
  for (genvar g = 0; g < 3; g++) begin : g_stub
    int            cnt = 0;
    logic          v = 1'b0;
    logic [2047:0] r = '0;
    always @(posedge clk) begin
      v <= 1'b0;
      if (cnt > 1) cnt <= cnt - 1;
      else if (cnt == 1) begin
        cnt <= 0;
        v   <= 1'b1;
        r   <= sconst[g] ? {256{sval[g]}} : sa_mul(m1[g], m2[g]);
      end else if (st[g]) cnt <= int'($urandom_range(1, 5));
      else if ($urandom_range(0, 7) == 0) begin
        v <= 1'b1;
        r <= {256{8'h55}};
      end
    end
    assign vld[g] = v;
    assign res[g] = r;
  end

  int ga [32][128];
  int gb [128][32];

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction

  function automatic int gold1(input int tr, input int tc,
                               input int i, input int c);
    int s = 0;
    for (int k = 0; k < 128; k++)
      s += ga[tr*16+i][k] * gb[k][tc*16+c];
    return sat(s, 20);
  endfunction

  task automatic fill1(input int av, input int bv, input bit rnd);
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 128; k++) begin
        ga[i][k] = rnd ? int'($urandom_range(0, 4)) - 2 : av;
        gb[k][i] = rnd ? int'($urandom_range(0, 4)) - 2 : bv;
      end
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 128; k++) begin
        a1[(i*128+k)*8 +: 8] = 8'(ga[i][k]);
        b1[(k*32+i)*8 +: 8]  = 8'(gb[k][i]);
      end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, " busy"}, busy1, 0);
    chk({tag, " done"}, done1, 0);
    chk({tag, " dvld"}, dv1, 0);
    chk({tag, " sa_start"}, st[0], 0);
    chk({tag, " clearn"}, clrn[0], 1);
    chk({tag, " m_dim"}, mdim1, 16);
    chk({tag, " row"}, row1, 0);
    chk({tag, " col"}, col1, 0);
    chk({tag, " out"}, |out1, 0);
    chk({tag, " mat1"}, |m1[0], 0);
    chk({tag, " mat2"}, |m2[0], 0);
  endtask

  task automatic kick1();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_st(input int n, input string tag);
    int seen = 0;
    for (int c = 0; c < 2000 && seen < n; c++) begin
      @(negedge clk);
      if (st[0]) seen++;
    end
    chk({tag, " reach pass"}, seen, n);
  endtask

  task automatic quiet1(input string tag);
    int ev = 0;
    repeat (20) begin
      @(negedge clk);
      if (dv1 || done1 || busy1) ev++;
    end
    chk({tag, " quiet"}, ev, 0);
  endtask

  task automatic run1(input bit extra, input string tag);
    int tiles = 0, dones = 0, starts = 0, npass = 0, lows = 0;
    int cyc, bad, fe, fg, fx, got, want;
    kick1();
    chk({tag, " busy"}, busy1, 1);
    for (cyc = 0; cyc < 6000 && busy1; cyc++) begin
      if (st[0]) begin
        if (npass > 0) chk({tag, " clearn"}, lows, 1);
        npass++;
        starts++;
        lows = 0;
      end
      if (!clrn[0]) lows++;
      if (dv1) begin
        chk({tag, " row"}, row1, tiles / 2);
        chk({tag, " col"}, col1, tiles % 2);
        chk({tag, " passes"}, starts, 8);
        starts = 0;
        bad = 0; fe = 0; fg = 0; fx = 0;
        for (int e = 0; e < 256; e++) begin
          got  = $signed(out1[e*20 +: 20]);
          want = gold1(tiles / 2, tiles % 2, e / 16, e % 16);
          if (got != want) begin
            if (bad == 0) begin fe = e; fg = got; fx = want; end
            bad++;
          end
        end
        n_checks++;
        assert (bad == 0) else begin
          n_errors++;
          $error("FAIL %s tile%0d: %0d bad, elem %0d got %0d expected %0d",
                 tag, tiles, bad, fe, fg, fx);
        end
        tiles++;
      end
      if (done1) begin
        dones++;
        chk({tag, " busy at done"}, busy1, 1);
      end
      start1 = extra && (cyc == 40 || done1);
      @(negedge clk);
    end
    start1 = 1'b0;
    chk({tag, " no timeout"}, cyc < 6000, 1);
    chk({tag, " tiles"}, tiles, 4);
    chk({tag, " dones"}, dones, 1);
    chk({tag, " hold"}, 64'($signed(out1[19:0])), 64'(gold1(1, 1, 0, 0)));
    repeat (5) @(negedge clk);
    chk({tag, " idle after"}, busy1, 0);
  endtask

  task automatic run_small(input int which, input int expv, input string tag);
    int tiles = 0, dones = 0, starts = 0, cyc, bad, fg, got;
    @(negedge clk);
    if (which == 2) start2 = 1'b1;
    else start3 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    chk({tag, " busy"}, which == 2 ? busy2 : busy3, 1);
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (!(which == 2 ? busy2 : busy3)) break;
      if (st[which-1]) starts++;
      if (which == 2 ? dv2 : dv3) begin
        chk({tag, " row"}, which == 2 ? row2 : row3, 0);
        chk({tag, " col"}, which == 2 ? col2 : col3, 0);
        bad = 0; fg = 0;
        for (int e = 0; e < 256; e++) begin
          got = which == 2 ? int'($signed(out2[e*20 +: 20]))
                           : int'($signed(out3[e*10 +: 10]));
          if (got != expv) begin
            if (bad == 0) fg = got;
            bad++;
          end
        end
        n_checks++;
        assert (bad == 0) else begin
          n_errors++;
          $error("FAIL %s tile: %0d bad, first got %0d expected %0d",
                 tag, bad, fg, expv);
        end
        tiles++;
      end
      if (which == 2 ? done2 : done3) dones++;
      @(negedge clk);
    end
    chk({tag, " no timeout"}, cyc < 3000, 1);
    chk({tag, " tiles"}, tiles, 1);
    chk({tag, " dones"}, dones, 1);
    chk({tag, " passes"}, starts, which == 2 ? 1 : 8);
  endtask

  initial begin
    rst_n  = 1'b0;
    srst_n = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    sconst = '{1'b0, 1'b0, 1'b1};
    sval   = '{8'h00, 8'h00, 8'h7F};
    a2 = {256{8'h01}};
    b2 = {256{8'h01}};
    a3 = '0;
    b3 = '0;
    fill1(1, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk_idle1("reset");
    chk("reset mdim3", mdim3, 16);
    chk("reset clearn3", clrn[2], 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_small(2, 16, "single");
    run_small(3, 511, "sat_pos");
    sval[2] = 8'h80;
    run_small(3, -512, "sat_neg");

    run1(1'b0, "ones_x2");
    run1(1'b1, "restart_ignored");

    fill1(0, 0, 1'b1);
    kick1();
    wait_st(3, "arst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle1("arst");
    @(negedge clk);
    rst_n = 1'b1;
    quiet1("arst");
    run1(1'b0, "rand_a");

    fill1(0, 0, 1'b1);
    kick1();
    wait_st(2, "srst");
    srst_n = 1'b0;
    @(negedge clk);
    chk_idle1("srst");
    srst_n = 1'b1;
    quiet1("srst");
    run1(1'b0, "rand_b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
